// File: rtl/debug_host_fsm_pkg.sv
// Shared constants and state types for the debug-link host initiator.
// Opcode values must match the debug unit on the far side of the UART.
package debug_host_fsm_pkg;

    localparam int DBG_UART_BITS        = 8;
    localparam int DBG_INSTRUCTION_BITS = 32;

    localparam logic [1:0] OP_LOAD_INST = 2'd1;
    localparam logic [1:0] OP_RUN       = 2'd2;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_NO_HALT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_OP,
        ST_WAIT_OP,
        ST_FETCH,
        ST_LATCH,
        ST_WORD,
        ST_RX_FRAME,
        ST_DONE
    } host_state_e;

    typedef enum logic [1:0] {
        WT_IDLE,
        WT_SEND,
        WT_WAIT
    } word_tx_state_e;

    typedef struct packed {
        host_state_e    host;
        word_tx_state_e word;
    } dbg_state_t;

    function automatic logic is_valid_cmd(input logic [1:0] cmd);
        return (cmd == OP_LOAD_INST) || (cmd == OP_RUN);
    endfunction

endpackage

// File: rtl/debug_host_fsm_if.sv
// Link bundle between the host FSM and its UART, program ROM and frame buffer.
// All *_start/*_done/*_we signals are single-cycle pulses; a TX byte is owned by
// the UART from the o_tx_start pulse until its i_tx_done pulse, and o_tx_data is
// stable over that window. i_rx_done qualifies i_rx_data for that cycle only.
interface debug_host_fsm_if
    import debug_host_fsm_pkg::*;
#(
    parameter int UART_BITS        = DBG_UART_BITS,
    parameter int INSTRUCTION_BITS = DBG_INSTRUCTION_BITS,
    parameter int PROG_ADDR_BITS   = 8,
    parameter int FRAME_ADDR_BITS  = 8
);
    logic [PROG_ADDR_BITS-1:0]   o_prog_addr;
    logic [INSTRUCTION_BITS-1:0] i_prog_data;
    logic                        o_tx_start;
    logic [UART_BITS-1:0]        o_tx_data;
    logic                        i_tx_done;
    logic                        i_rx_done;
    logic [UART_BITS-1:0]        i_rx_data;
    logic                        o_frame_we;
    logic [FRAME_ADDR_BITS-1:0]  o_frame_addr;
    logic [UART_BITS-1:0]        o_frame_data;

    modport master (
        output o_prog_addr, o_tx_start, o_tx_data, o_frame_we, o_frame_addr, o_frame_data,
        input  i_prog_data, i_tx_done, i_rx_done, i_rx_data
    );

    modport slave (
        input  o_prog_addr, o_tx_start, o_tx_data, o_frame_we, o_frame_addr, o_frame_data,
        output i_prog_data, i_tx_done, i_rx_done, i_rx_data
    );

endinterface

// File: rtl/debug_host_word_tx.sv
// Serialises one program word into UART bytes, MSB first, with a per-byte
// tx_done timeout. done_o pulses once per word; timeout_o qualifies it.
module debug_host_word_tx
    import debug_host_fsm_pkg::*;
#(
    parameter int UART_BITS        = DBG_UART_BITS,
    parameter int INSTRUCTION_BITS = DBG_INSTRUCTION_BITS,
    parameter int TIMEOUT_BITS     = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [INSTRUCTION_BITS-1:0] word_i,
    output logic                        tx_start_o,
    output logic [UART_BITS-1:0]        tx_data_o,
    input  logic                        tx_done_i,
    output logic                        done_o,
    output logic                        timeout_o,
    output word_tx_state_e              state_o
);
    localparam int NBYTES   = INSTRUCTION_BITS / UART_BITS;
    localparam int IDX_BITS = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_BITS-1:0]     LAST_IDX = IDX_BITS'(NBYTES - 1);
    localparam logic [TIMEOUT_BITS-1:0] TO_ONES  = '1;
    // Leaving on the edge that would saturate the counter gives exactly 2^N-1 idle cycles.
    localparam logic [TIMEOUT_BITS-1:0] TO_LAST  = TO_ONES - TIMEOUT_BITS'(1);

    word_tx_state_e              state_q;
    logic [INSTRUCTION_BITS-1:0] shreg_q;
    logic [IDX_BITS-1:0]         idx_q;
    logic [TIMEOUT_BITS-1:0]     to_q;
    logic                        tx_start_q;
    logic [UART_BITS-1:0]        tx_data_q;
    logic                        done_q;
    logic                        timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= WT_IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            to_q       <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                WT_IDLE: begin
                    if (start_i) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= word_i[INSTRUCTION_BITS-1 -: UART_BITS];
                        shreg_q    <= word_i << UART_BITS;
                        idx_q      <= '0;
                        timeout_q  <= 1'b0;
                        state_q    <= WT_SEND;
                    end
                end
                WT_SEND: begin
                    to_q    <= '0;
                    state_q <= WT_WAIT;
                end
                WT_WAIT: begin
                    if (tx_done_i) begin
                        to_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= WT_IDLE;
                        end else begin
                            tx_start_q <= 1'b1;
                            tx_data_q  <= shreg_q[INSTRUCTION_BITS-1 -: UART_BITS];
                            shreg_q    <= shreg_q << UART_BITS;
                            idx_q      <= idx_q + IDX_BITS'(1);
                            state_q    <= WT_SEND;
                        end
                    end else if (to_q == TO_LAST) begin
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= WT_IDLE;
                    end else begin
                        to_q <= to_q + TIMEOUT_BITS'(1);
                    end
                end
                default: state_q <= WT_IDLE;
            endcase
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign done_o     = done_q;
    assign timeout_o  = timeout_q;
    assign state_o    = state_q;

endmodule

// File: rtl/debug_host_fsm.sv
// Host-side initiator for the debug UART link: sends LOAD/RUN opcodes, streams
// program words from a sync ROM, and stores the returned dump frame.
module debug_host_fsm
    import debug_host_fsm_pkg::*;
#(
    parameter int                          UART_BITS        = DBG_UART_BITS,
    parameter int                          INSTRUCTION_BITS = DBG_INSTRUCTION_BITS,
    parameter int                          PROG_ADDR_BITS   = 8,
    parameter int                          FRAME_BYTES      = 160,
    parameter int                          FRAME_ADDR_BITS  = 8,
    parameter logic [INSTRUCTION_BITS-1:0] HALT_WORD        = 32'hFC000000,
    parameter int                          TIMEOUT_BITS     = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [1:0]             i_cmd,
    debug_host_fsm_if.master       link,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [1:0]             o_error,
    output dbg_state_t             o_dbg_state
);
    localparam logic [TIMEOUT_BITS-1:0]    TO_ONES    = '1;
    localparam logic [TIMEOUT_BITS-1:0]    TO_LAST    = TO_ONES - TIMEOUT_BITS'(1);
    localparam logic [FRAME_ADDR_BITS-1:0] FRAME_LAST = FRAME_ADDR_BITS'(FRAME_BYTES - 1);

    host_state_e                 state_q;
    logic [1:0]                  cmd_q;
    logic [PROG_ADDR_BITS-1:0]   prog_addr_q;
    logic [FRAME_ADDR_BITS-1:0]  frame_cnt_q;
    logic [TIMEOUT_BITS-1:0]     to_q;
    logic                        halt_q;
    logic                        op_tx_start_q;
    logic [UART_BITS-1:0]        op_tx_data_q;
    logic                        word_start_q;
    logic                        done_q;
    logic [1:0]                  error_q;

    logic                        word_tx_start;
    logic [UART_BITS-1:0]        word_tx_data;
    logic                        word_done;
    logic                        word_timeout;
    word_tx_state_e              word_state;
    logic                        to_expired;
    logic                        rx_accept;

    assign to_expired = (to_q == TO_LAST);
    assign rx_accept  = (state_q == ST_RX_FRAME) && link.i_rx_done;

    debug_host_word_tx #(
        .UART_BITS       (UART_BITS),
        .INSTRUCTION_BITS(INSTRUCTION_BITS),
        .TIMEOUT_BITS    (TIMEOUT_BITS)
    ) u_word_tx (
        .clk       (clk),
        .rst       (rst),
        .start_i   (word_start_q),
        .word_i    (link.i_prog_data),
        .tx_start_o(word_tx_start),
        .tx_data_o (word_tx_data),
        .tx_done_i (link.i_tx_done),
        .done_o    (word_done),
        .timeout_o (word_timeout),
        .state_o   (word_state)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            prog_addr_q   <= '0;
            frame_cnt_q   <= '0;
            to_q          <= '0;
            halt_q        <= 1'b0;
            op_tx_start_q <= 1'b0;
            op_tx_data_q  <= '0;
            word_start_q  <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= ERR_OK;
        end else begin
            op_tx_start_q <= 1'b0;
            word_start_q  <= 1'b0;
            done_q        <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start && is_valid_cmd(i_cmd)) begin
                        error_q       <= ERR_OK;
                        prog_addr_q   <= '0;
                        frame_cnt_q   <= '0;
                        cmd_q         <= i_cmd;
                        op_tx_start_q <= 1'b1;
                        op_tx_data_q  <= UART_BITS'(i_cmd);
                        state_q       <= ST_SEND_OP;
                    end
                end
                ST_SEND_OP: begin
                    to_q    <= '0;
                    state_q <= ST_WAIT_OP;
                end
                ST_WAIT_OP: begin
                    if (link.i_tx_done) begin
                        to_q    <= '0;
                        state_q <= (cmd_q == OP_LOAD_INST) ? ST_FETCH : ST_RX_FRAME;
                    end else if (to_expired) begin
                        done_q  <= 1'b1;
                        error_q <= ERR_TIMEOUT;
                        state_q <= ST_DONE;
                    end else begin
                        to_q <= to_q + TIMEOUT_BITS'(1);
                    end
                end
                // Address was presented on entry to FETCH; ROM data is valid during LATCH.
                ST_FETCH: begin
                    word_start_q <= 1'b1;
                    state_q      <= ST_LATCH;
                end
                ST_LATCH: begin
                    halt_q  <= (link.i_prog_data == HALT_WORD);
                    state_q <= ST_WORD;
                end
                ST_WORD: begin
                    if (word_done) begin
                        if (word_timeout) begin
                            done_q  <= 1'b1;
                            error_q <= ERR_TIMEOUT;
                            state_q <= ST_DONE;
                        end else if (halt_q) begin
                            done_q  <= 1'b1;
                            error_q <= ERR_OK;
                            state_q <= ST_DONE;
                        end else if (prog_addr_q == '1) begin
                            done_q  <= 1'b1;
                            error_q <= ERR_NO_HALT;
                            state_q <= ST_DONE;
                        end else begin
                            prog_addr_q <= prog_addr_q + PROG_ADDR_BITS'(1);
                            state_q     <= ST_FETCH;
                        end
                    end
                end
                ST_RX_FRAME: begin
                    if (link.i_rx_done) begin
                        to_q        <= '0;
                        frame_cnt_q <= frame_cnt_q + FRAME_ADDR_BITS'(1);
                        if (frame_cnt_q == FRAME_LAST) begin
                            done_q  <= 1'b1;
                            error_q <= ERR_OK;
                            state_q <= ST_DONE;
                        end
                    end else if (to_expired) begin
                        done_q  <= 1'b1;
                        error_q <= ERR_TIMEOUT;
                        state_q <= ST_DONE;
                    end else begin
                        to_q <= to_q + TIMEOUT_BITS'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Frame writes bypass the registers so a byte lands in the same cycle it arrives.
    assign link.o_prog_addr  = prog_addr_q;
    assign link.o_tx_start   = op_tx_start_q | word_tx_start;
    assign link.o_tx_data    = (state_q == ST_WORD) ? word_tx_data : op_tx_data_q;
    assign link.o_frame_we   = rx_accept;
    assign link.o_frame_addr = frame_cnt_q;
    assign link.o_frame_data = rx_accept ? link.i_rx_data : '0;

    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = done_q;
    assign o_error     = error_q;
    assign o_dbg_state = '{host: state_q, word: word_state};

endmodule

// File: tb/tb_debug_host_fsm.sv
// Self-checking bench for debug_host_fsm: UART TX model with 10-cycle done,
// sync ROM model, RX byte feeder and frame-write scoreboard.
module tb_debug_host_fsm;
    import debug_host_fsm_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [1:0]  i_cmd;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_error;
    dbg_state_t  dbg_state;

    debug_host_fsm_if #(.PROG_ADDR_BITS(2)) link ();

    debug_host_fsm #(
        .PROG_ADDR_BITS(2),
        .TIMEOUT_BITS  (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_cmd      (i_cmd),
        .link       (link),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error),
        .o_dbg_state(dbg_state)
    );

    localparam logic [31:0] HALT = 32'hFC000000;

    typedef struct {
        string      name;
        logic [1:0] cmd;
        int         rom_sel;
        int         rx_bytes;
        int         exp_tx;
        int         exp_we;
        logic [1:0] exp_err;
        int         exp_done;
        int         exp_lat;
        int         exp_addr;
    } vec_t;

    int          n_vec = 0;
    int          n_miscmp = 0;
    int          cyc = 0;
    int          tx_cnt = 0;
    int          we_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_rx_cyc = 0;
    logic [31:0] rom [4];
    logic [7:0]  exp_q [$];
    logic [15:0] exp_fq [$];
    vec_t        vecs [6];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- models ----------------
    always @(posedge clk) link.i_prog_data <= rom[link.o_prog_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin : tx_model
        int cnt;
        cnt = 0;
        link.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            link.i_tx_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) link.i_tx_done = 1'b1;
            end
            if (link.o_tx_start === 1'b1) begin
                tx_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miscmp++;
                    $display("FAIL tx_extra: got byte %02h, expected no transmission", link.o_tx_data);
                end else begin
                    check("tx_byte", 32'(link.o_tx_data), 32'(exp_q.pop_front()));
                end
                cnt = 10;
            end
        end
    end

    always @(negedge clk) begin
        if (link.o_frame_we === 1'b1) begin
            we_cnt++;
            if (exp_fq.size() == 0) begin
                n_vec++;
                n_miscmp++;
                $display("FAIL frame_extra: got write addr %0d data %02h, expected none",
                         link.o_frame_addr, link.o_frame_data);
            end else begin
                check("frame_wr", 32'({link.o_frame_addr, link.o_frame_data}), 32'(exp_fq.pop_front()));
            end
        end
        if (o_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_rom(input int sel);
        if (sel == 0) begin
            rom[0] = 32'h20010005; rom[1] = HALT; rom[2] = 32'h0; rom[3] = 32'h0;
        end else begin
            rom[0] = 32'h12345678; rom[1] = 32'h9ABCDEF0; rom[2] = 32'h0F0F0F0F; rom[3] = 32'hDEADBEEF;
        end
    endtask

    task automatic push_load_bytes();
        logic [31:0] w;
        exp_q.push_back(8'h01);
        for (int a = 0; a < 4; a++) begin
            w = rom[a];
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
            if (w == HALT) break;
        end
    endtask

    task automatic pulse_start(input logic [1:0] cmd);
        @(negedge clk);
        i_start = 1'b1;
        i_cmd   = cmd;
        @(negedge clk);
        i_start = 1'b0;
        i_cmd   = 2'd0;
    endtask

    task automatic feed_rx(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            link.i_rx_done = 1'b1;
            link.i_rx_data = 8'(i);
            exp_fq.push_back({8'(i), 8'(i)});
            last_rx_cyc = cyc + 1;
            @(negedge clk);
            link.i_rx_done = 1'b0;
            link.i_rx_data = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic pulse_rx_noise();
        @(negedge clk);
        link.i_rx_done = 1'b1;
        link.i_rx_data = 8'hAA;
        @(negedge clk);
        link.i_rx_done = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > base) break;
        end
    endtask

    task automatic run_row(input vec_t v);
        int tx0, we0, d0;
        load_rom(v.rom_sel);
        tx0 = tx_cnt;
        we0 = we_cnt;
        d0  = done_cnt;
        if (v.cmd == OP_LOAD_INST) push_load_bytes();
        else if (v.cmd == OP_RUN) exp_q.push_back(8'h02);
        pulse_start(v.cmd);
        if (v.cmd == OP_RUN) begin
            repeat (14) @(negedge clk);
            feed_rx(v.rx_bytes);
        end
        if (v.exp_done != 0) wait_done(d0, 4000);
        else repeat (30) @(negedge clk);
        repeat (2) @(negedge clk);
        check({v.name, "_done_cnt"}, 32'(done_cnt - d0), 32'(v.exp_done));
        check({v.name, "_tx_cnt"},   32'(tx_cnt - tx0),   32'(v.exp_tx));
        check({v.name, "_we_cnt"},   32'(we_cnt - we0),   32'(v.exp_we));
        check({v.name, "_busy"},     32'(o_busy),         32'(0));
        if (v.exp_done != 0) begin
            check({v.name, "_error"},     32'(o_error),       32'(v.exp_err));
            check({v.name, "_tx_q_left"}, 32'(exp_q.size()),  32'(0));
            check({v.name, "_fr_q_left"}, 32'(exp_fq.size()), 32'(0));
        end
        if (v.exp_lat >= 0) check({v.name, "_done_lat"}, 32'(done_cyc - last_rx_cyc), 32'(v.exp_lat));
        if (v.exp_addr >= 0) check({v.name, "_prog_addr"}, 32'(link.o_prog_addr), 32'(v.exp_addr));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},       32'(o_busy),            32'(0));
        check({tag, "_done"},       32'(o_done),            32'(0));
        check({tag, "_error"},      32'(o_error),           32'(0));
        check({tag, "_tx_start"},   32'(link.o_tx_start),   32'(0));
        check({tag, "_tx_data"},    32'(link.o_tx_data),    32'(0));
        check({tag, "_prog_addr"},  32'(link.o_prog_addr),  32'(0));
        check({tag, "_frame_we"},   32'(link.o_frame_we),   32'(0));
        check({tag, "_frame_addr"}, 32'(link.o_frame_addr), 32'(0));
        check({tag, "_frame_data"}, 32'(link.o_frame_data), 32'(0));
        check({tag, "_dbg_state"},  32'(dbg_state),         32'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int d0, tx0, we0;
        vecs[0] = '{"ign_cmd3",    2'd3, 0, 0,   0,  0,   2'd0, 0, -1, -1};
        vecs[1] = '{"ign_cmd0",    2'd0, 0, 0,   0,  0,   2'd0, 0, -1, -1};
        vecs[2] = '{"load_halt",   2'd1, 0, 0,   9,  0,   2'd0, 1, -1,  1};
        vecs[3] = '{"run_full",    2'd2, 0, 160, 1,  160, 2'd0, 1,  0, -1};
        vecs[4] = '{"run_short",   2'd2, 0, 5,   1,  5,   2'd1, 1, 63, -1};
        vecs[5] = '{"load_nohalt", 2'd1, 1, 0,   17, 0,   2'd2, 1, -1,  3};

        rst = 1'b0;
        i_start = 1'b0;
        i_cmd = 2'd0;
        link.i_rx_done = 1'b0;
        link.i_rx_data = 8'd0;
        load_rom(0);
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");

        for (int i = 0; i < 6; i++) run_row(vecs[i]);

        // Noise on a LOAD must not change what goes out on the wire.
        load_rom(0);
        tx0 = tx_cnt; we0 = we_cnt; d0 = done_cnt;
        push_load_bytes();
        pulse_start(2'd3);
        pulse_start(OP_LOAD_INST);
        repeat (5) @(negedge clk);
        pulse_rx_noise();
        pulse_start(OP_RUN);
        repeat (20) @(negedge clk);
        pulse_rx_noise();
        pulse_start(2'd3);
        pulse_start(OP_LOAD_INST);
        wait_done(d0, 4000);
        repeat (2) @(negedge clk);
        check("noise_done_cnt", 32'(done_cnt - d0),  32'(1));
        check("noise_tx_cnt",   32'(tx_cnt - tx0),   32'(9));
        check("noise_we_cnt",   32'(we_cnt - we0),   32'(0));
        check("noise_error",    32'(o_error),        32'(0));
        check("noise_tx_q",     32'(exp_q.size()),   32'(0));

        // Reset in the middle of a frame: async clear, no done pulse, clean rerun.
        d0 = done_cnt;
        exp_q.push_back(8'h02);
        pulse_start(OP_RUN);
        repeat (14) @(negedge clk);
        feed_rx(20);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(o_busy), 32'(1));
        #1 rst = 1'b0;
        #1 check_idle_outputs("mid_rx_reset");
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (80) @(negedge clk);
        check("rst_no_done", 32'(done_cnt - d0), 32'(0));
        check("rst_fr_q",    32'(exp_fq.size()), 32'(0));
        run_row(vecs[3]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
